// File: rtl/conv_layer_seq_pkg.sv
// Shared types and default geometry for the layer-1 convolution sequencer:
// 96x96 input maps, 9x9 kernel, 88x88 outputs, 16-bit signed pixels.
package conv_layer_seq_pkg;

  localparam int IMG_DIM = 96;
  localparam int KER_DIM = 9;
  localparam int OUT_DIM = IMG_DIM - KER_DIM + 1;

  localparam int DEF_IMG_PIX      = IMG_DIM * IMG_DIM;
  localparam int DEF_START_OFFSET = KER_DIM * IMG_DIM;
  localparam int DEF_OUT_NUM      = OUT_DIM * OUT_DIM;
  localparam int DEF_DRAIN_MAX    = 1024;
  localparam int DEF_IN_AW        = 14;
  localparam int DEF_OUT_AW       = 13;

  localparam int PIX_W = 16;
  typedef logic signed [PIX_W-1:0] pix_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FILL,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/conv_layer_seq_if.sv
// Command, frame-buffer read, engine and output-buffer write signals of one
// sequencer; master is the sequencer side, slave the surrounding datapath.
interface conv_layer_seq_if
  import conv_layer_seq_pkg::*;
#(
  parameter int IN_AW  = DEF_IN_AW,
  parameter int OUT_AW = DEF_OUT_AW
);

  logic              cmd_start;
  logic              cmd_abort;
  logic              busy;
  logic              done;
  logic              err;
  logic              rd_en;
  logic [IN_AW-1:0]  rd_addr;
  pix_t              rd_data;
  logic              eng_rst;
  logic              eng_start;
  pix_t              eng_map_in;
  logic              eng_save;
  pix_t              eng_map_out;
  logic              wr_en;
  logic [OUT_AW-1:0] wr_addr;
  pix_t              wr_data;

  modport master (
    input  cmd_start, cmd_abort, rd_data, eng_save, eng_map_out,
    output busy, done, err, rd_en, rd_addr, eng_rst, eng_start, eng_map_in,
           wr_en, wr_addr, wr_data
  );

  modport slave (
    output cmd_start, cmd_abort, rd_data, eng_save, eng_map_out,
    input  busy, done, err, rd_en, rd_addr, eng_rst, eng_start, eng_map_in,
           wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/conv_layer_seq_capture.sv
// Registers each engine save into an output-buffer write one cycle later and
// counts outputs, dropping saves once the map's output count is complete.
module conv_out_capture
  import conv_layer_seq_pkg::*;
#(
  parameter int OUT_AW  = DEF_OUT_AW,
  parameter int OUT_NUM = DEF_OUT_NUM
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic              eng_save_i,
  input  pix_t              eng_map_out_i,
  output logic              wr_en_o,
  output logic [OUT_AW-1:0] wr_addr_o,
  output pix_t              wr_data_o,
  output logic              full_o
);

  localparam int CW = OUT_AW + 1;
  localparam logic [CW-1:0] OUT_NUM_C = CW'(OUT_NUM);

  logic [CW-1:0]     out_cnt_q, out_cnt_d;
  logic              wr_en_q, wr_en_d;
  logic [OUT_AW-1:0] wr_addr_q, wr_addr_d;
  pix_t              wr_data_q, wr_data_d;
  logic              take;

  always_comb begin
    take      = en_i && eng_save_i && (out_cnt_q != OUT_NUM_C);
    out_cnt_d = out_cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (clr_i) begin
      out_cnt_d = '0;
    end else if (take) begin
      wr_en_d   = 1'b1;
      wr_addr_d = out_cnt_q[OUT_AW-1:0];
      wr_data_d = eng_map_out_i;
      out_cnt_d = out_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      out_cnt_q <= out_cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  assign full_o    = (out_cnt_q == OUT_NUM_C);

endmodule

// File: rtl/conv_layer_seq.sv
// Sequencer for one convolution engine: clears it, streams one input map from
// the frame buffer, opens the start window and stores every engine output.
module conv_layer_seq
  import conv_layer_seq_pkg::*;
#(
  parameter int IMG_PIX      = DEF_IMG_PIX,
  parameter int START_OFFSET = DEF_START_OFFSET,
  parameter int OUT_NUM      = DEF_OUT_NUM,
  parameter int DRAIN_MAX    = DEF_DRAIN_MAX,
  parameter int IN_AW        = DEF_IN_AW,
  parameter int OUT_AW       = DEF_OUT_AW
) (
  input logic               clk_in,
  input logic               rst_n,
  conv_layer_seq_if.master  bus
);

  localparam int PW = IN_AW + 1;
  localparam int DW = $clog2(DRAIN_MAX) + 1;
  localparam logic [IN_AW-1:0] LAST_ADDR = IN_AW'(IMG_PIX - 1);
  localparam logic [PW-1:0]    PRES_ARM  = PW'(START_OFFSET - 1);
  localparam logic [PW-1:0]    PRES_END  = PW'(IMG_PIX);
  localparam logic [DW-1:0]    DRAIN_END = DW'(DRAIN_MAX - 1);

  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             rd_en_q, rd_en_d;
  logic [IN_AW-1:0] rd_addr_q, rd_addr_d;
  logic             rd_valid_q;
  logic             eng_rst_q, eng_rst_d;
  logic             eng_start_q, eng_start_d;
  pix_t             eng_map_in_q, eng_map_in_d;
  logic [PW-1:0]    pres_cnt_q, pres_cnt_d;
  logic [DW-1:0]    drain_cnt_q, drain_cnt_d;

  logic accept, abort, feeding, pres_inc, pres_take, full, timeout, cap_en;

  assign accept   = (state_q == ST_IDLE) && bus.cmd_start;
  assign abort    = (state_q != ST_IDLE) && bus.cmd_abort;
  assign feeding  = (state_q == ST_FILL) || (state_q == ST_RUN);
  assign pres_inc = feeding && rd_valid_q;
  assign timeout  = (state_q == ST_DRAIN) && (drain_cnt_q == DRAIN_END) && !full;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FILL hands over to RUN in the same edge that loads the START_OFFSET-th pixel.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (bus.cmd_start) state_d = ST_CLEAR;
      ST_CLEAR: state_d = ST_FILL;
      ST_FILL: begin
        if (full)                                     state_d = ST_DONE;
        else if (pres_inc && (pres_cnt_q == PRES_ARM)) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (full)                        state_d = ST_DONE;
        else if (pres_cnt_q == PRES_END) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (full)         state_d = ST_DONE;
        else if (timeout) state_d = ST_IDLE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  always_comb begin
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
    eng_rst_d   = (state_d inside {ST_IDLE, ST_CLEAR, ST_DONE});
    eng_start_d = (state_d inside {ST_RUN, ST_DRAIN});

    err_d = err_q;
    if (accept)                err_d = 1'b0;
    else if (timeout && !abort) err_d = 1'b1;

    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    if (accept) begin
      rd_addr_d = '0;
    end else if ((state_q == ST_CLEAR) && (state_d == ST_FILL)) begin
      rd_en_d   = 1'b1;
      rd_addr_d = '0;
    end else if (rd_en_q && feeding && (state_d inside {ST_FILL, ST_RUN}) &&
                 (rd_addr_q != LAST_ADDR)) begin
      rd_en_d   = 1'b1;
      rd_addr_d = rd_addr_q + 1'b1;
    end

    pres_take    = pres_inc && (state_d inside {ST_FILL, ST_RUN});
    eng_map_in_d = pres_take ? bus.rd_data : '0;
    pres_cnt_d   = accept ? '0 : (pres_take ? pres_cnt_q + 1'b1 : pres_cnt_q);
    drain_cnt_d  = accept ? '0 :
                   ((state_q == ST_DRAIN) ? drain_cnt_q + 1'b1 : drain_cnt_q);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      rd_valid_q   <= 1'b0;
      eng_rst_q    <= 1'b1;
      eng_start_q  <= 1'b0;
      eng_map_in_q <= '0;
      pres_cnt_q   <= '0;
      drain_cnt_q  <= '0;
    end else begin
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      rd_valid_q   <= rd_en_q;
      eng_rst_q    <= eng_rst_d;
      eng_start_q  <= eng_start_d;
      eng_map_in_q <= eng_map_in_d;
      pres_cnt_q   <= pres_cnt_d;
      drain_cnt_q  <= drain_cnt_d;
    end
  end

  // Saves are only taken while the map stays active, so abort, timeout and
  // completion all discard a write that would otherwise land after them.
  assign cap_en = (state_q inside {ST_FILL, ST_RUN, ST_DRAIN}) &&
                  (state_d inside {ST_FILL, ST_RUN, ST_DRAIN});

  conv_out_capture #(
    .OUT_AW  (OUT_AW),
    .OUT_NUM (OUT_NUM)
  ) u_capture (
    .clk_in        (clk_in),
    .rst_n         (rst_n),
    .clr_i         (accept),
    .en_i          (cap_en),
    .eng_save_i    (bus.eng_save),
    .eng_map_out_i (bus.eng_map_out),
    .wr_en_o       (bus.wr_en),
    .wr_addr_o     (bus.wr_addr),
    .wr_data_o     (bus.wr_data),
    .full_o        (full)
  );

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.rd_en      = rd_en_q;
  assign bus.rd_addr    = rd_addr_q;
  assign bus.eng_rst    = eng_rst_q;
  assign bus.eng_start  = eng_start_q;
  assign bus.eng_map_in = eng_map_in_q;

endmodule

// File: tb/tb_conv_layer_seq.sv
// Directed bench for conv_layer_seq with a ramp frame buffer and a periodic
// engine model (saves in cycles 5..92 of each 96-cycle period).
module tb_conv_layer_seq;
  import conv_layer_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv_layer_seq_if bus ();

  conv_layer_seq dut (
    .clk_in (clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;
  int n_wr, n_wr_err, n_done, n_rd, n_rd_err;
  int eng_t, eng_k;
  bit eng_mute = 1'b0;

  function automatic logic [15:0] exp_val(input int k);
    return 16'((k * 29 + 11) ^ 16'h3C3C);
  endfunction

  // Ramp frame buffer: pixel = address, one cycle read latency.
  always @(posedge clk) bus.rd_data <= bus.rd_en ? pix_t'(bus.rd_addr) : pix_t'(16'h7BAD);

  // Engine model, driven mid-cycle from the DUT's registered eng_start/eng_rst.
  always @(negedge clk) begin
    if (bus.eng_start !== 1'b1 || bus.eng_rst !== 1'b0) begin
      eng_t = 0;
      bus.eng_save = 1'b0;
    end else begin
      bus.eng_save = !eng_mute && (eng_t / 96 < 88) && (eng_t % 96 >= 5) && (eng_t % 96 <= 92);
      if (bus.eng_save) begin
        bus.eng_map_out = pix_t'(exp_val(eng_k));
        eng_k++;
      end
      eng_t++;
    end
    if (bus.eng_rst !== 1'b0) eng_k = 0;
  end

  // Scoreboard: writes must be in-order addresses carrying the model's data.
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      if (bus.wr_addr !== 13'(n_wr) || bus.wr_data !== pix_t'(exp_val(n_wr))) n_wr_err++;
      n_wr++;
    end
    if (bus.done === 1'b1) n_done++;
    if (bus.rd_en === 1'b1) begin
      if (bus.rd_addr !== 14'(n_rd)) n_rd_err++;
      n_rd++;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_counts();
    n_wr = 0; n_wr_err = 0; n_done = 0; n_rd = 0; n_rd_err = 0;
  endtask

  task automatic test_reset();
    bus.cmd_start = 1'b0;
    bus.cmd_abort = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({bus.busy, bus.done, bus.err, bus.rd_en, bus.eng_rst, bus.eng_start, bus.wr_en} !== 7'b0000100) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 0000100", {bus.busy, bus.done, bus.err, bus.rd_en, bus.eng_rst, bus.eng_start, bus.wr_en});
    end
    checks++;
    if ({bus.rd_addr, bus.wr_addr} !== 27'd0) begin
      errors++;
      $display("FAIL reset_addr: got rd=%0d wr=%0d want 0 0", bus.rd_addr, bus.wr_addr);
    end
    checks++;
    if ({bus.eng_map_in, bus.wr_data} !== 32'd0) begin
      errors++;
      $display("FAIL reset_data: got map_in=%0d wr_data=%0d want 0 0", bus.eng_map_in, bus.wr_data);
    end
    rst_n = 1'b1;
    repeat (3) tick();
    checks++;
    if ({bus.busy, bus.eng_rst, bus.rd_en} !== 3'b010) begin
      errors++;
      $display("FAIL idle_after_reset: got %b want 010", {bus.busy, bus.eng_rst, bus.rd_en});
    end
    $display("test_reset: done");
  endtask

  task automatic test_full_map(input string tag);
    int cyc = 0;
    int done_cyc = -10;
    int idle_cyc = -1;
    bit seen_start = 1'b0;
    logic [15:0] prev_map, map_at_start, map_before;
    map_at_start = 16'hFFFF;
    map_before   = 16'hFFFF;
    clear_counts();
    bus.cmd_start = 1'b1;
    tick();
    bus.cmd_start = 1'b0;
    checks++;
    if ({bus.busy, bus.eng_rst, bus.rd_en, bus.err} !== 4'b1100) begin
      errors++;
      $display("FAIL %s clear_cycle: got busy/rst/rd/err=%b want 1100", tag, {bus.busy, bus.eng_rst, bus.rd_en, bus.err});
    end
    tick();
    checks++;
    if ({bus.rd_en, bus.eng_rst, bus.rd_addr} !== {2'b10, 14'd0}) begin
      errors++;
      $display("FAIL %s fill_entry: got rd_en=%b eng_rst=%b rd_addr=%0d want 1 0 0", tag, bus.rd_en, bus.eng_rst, bus.rd_addr);
    end
    prev_map = bus.eng_map_in;
    while (idle_cyc < 0 && cyc < 20000) begin
      // Stray start requests mid-map must be ignored.
      bus.cmd_start = bus.rd_en && (bus.rd_addr == 14'd3000 || bus.rd_addr == 14'd6000);
      tick();
      if (bus.eng_start === 1'b1 && !seen_start) begin
        seen_start   = 1'b1;
        map_at_start = bus.eng_map_in;
        map_before   = prev_map;
      end
      if (bus.done === 1'b1) done_cyc = cyc;
      if (bus.busy === 1'b0) idle_cyc = cyc;
      prev_map = bus.eng_map_in;
      cyc++;
    end
    bus.cmd_start = 1'b0;
    checks++;
    if (idle_cyc < 0) begin
      errors++;
      $display("FAIL %s finish_timeout: got busy after %0d cycles want idle", tag, cyc);
    end
    checks++;
    if (map_at_start !== 16'd863 || map_before !== 16'd862) begin
      errors++;
      $display("FAIL %s start_align: got pixel %0d (prev %0d) at eng_start rise want 863 (prev 862)", tag, map_at_start, map_before);
    end
    checks++;
    if (n_wr !== 7744 || n_wr_err !== 0) begin
      errors++;
      $display("FAIL %s writes: got %0d writes %0d bad want 7744 writes 0 bad", tag, n_wr, n_wr_err);
    end
    checks++;
    if (n_rd !== 9216 || n_rd_err !== 0) begin
      errors++;
      $display("FAIL %s reads: got %0d reads %0d out of order want 9216 0", tag, n_rd, n_rd_err);
    end
    checks++;
    if (n_done !== 1 || idle_cyc !== done_cyc + 1) begin
      errors++;
      $display("FAIL %s done_pulse: got %0d pulses idle_at=%0d done_at=%0d want 1 pulse idle one cycle after", tag, n_done, idle_cyc, done_cyc);
    end
    checks++;
    if ({bus.err, bus.eng_rst, bus.eng_start} !== 3'b010) begin
      errors++;
      $display("FAIL %s end_state: got err/rst/start=%b want 010", tag, {bus.err, bus.eng_rst, bus.eng_start});
    end
    $display("test_full_map %s: writes=%0d reads=%0d", tag, n_wr, n_rd);
  endtask

  task automatic test_timeout();
    int cyc = 0;
    int n = 0;
    bit seen_rd = 1'b0;
    eng_mute = 1'b1;
    clear_counts();
    bus.cmd_start = 1'b1;
    tick();
    bus.cmd_start = 1'b0;
    while (cyc < 12000 && !(seen_rd && bus.rd_en === 1'b0)) begin
      tick();
      if (bus.rd_en === 1'b1) seen_rd = 1'b1;
      cyc++;
    end
    while (bus.err !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 1026) begin
      errors++;
      $display("FAIL timeout_latency: got err %0d cycles after last read want 1026", n);
    end
    checks++;
    if ({bus.err, bus.busy, bus.eng_rst, bus.done} !== 4'b1010) begin
      errors++;
      $display("FAIL timeout_state: got err/busy/rst/done=%b want 1010", {bus.err, bus.busy, bus.eng_rst, bus.done});
    end
    checks++;
    if (n_done !== 0 || n_wr !== 0) begin
      errors++;
      $display("FAIL timeout_quiet: got %0d done %0d writes want 0 0", n_done, n_wr);
    end
    eng_mute = 1'b0;
    $display("test_timeout: err after %0d cycles", n);
  endtask

  task automatic test_abort();
    int cyc = 0;
    int n_before;
    bit found = 1'b0;
    clear_counts();
    bus.cmd_start = 1'b1;
    tick();
    bus.cmd_start = 1'b0;
    checks++;
    if ({bus.err, bus.busy} !== 2'b01) begin
      errors++;
      $display("FAIL err_clear: got err/busy=%b want 01", {bus.err, bus.busy});
    end
    while (!found && cyc < 8000) begin
      tick();
      found = (bus.rd_addr >= 14'd5000) && (bus.eng_save === 1'b1);
      cyc++;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL abort_setup: got no save near pixel 5000 in %0d cycles want one", cyc);
    end
    n_before = n_wr;
    bus.cmd_abort = 1'b1;
    tick();
    bus.cmd_abort = 1'b0;
    checks++;
    if ({bus.wr_en, bus.eng_rst, bus.busy, bus.rd_en, bus.eng_start} !== 5'b01000) begin
      errors++;
      $display("FAIL abort_next: got wr/rst/busy/rd/start=%b want 01000", {bus.wr_en, bus.eng_rst, bus.busy, bus.rd_en, bus.eng_start});
    end
    repeat (5) tick();
    checks++;
    if (n_wr !== n_before || n_done !== 0) begin
      errors++;
      $display("FAIL abort_quiet: got %0d writes %0d done want %0d writes 0 done", n_wr, n_done, n_before);
    end
    $display("test_abort: aborted at rd_addr=%0d writes=%0d", bus.rd_addr, n_before);
  endtask

  task automatic test_reset_mid_drain();
    int cyc = 0;
    int n_before;
    bit seen_rd = 1'b0;
    clear_counts();
    bus.cmd_start = 1'b1;
    tick();
    bus.cmd_start = 1'b0;
    while (cyc < 12000 && !(seen_rd && bus.rd_en === 1'b0)) begin
      tick();
      if (bus.rd_en === 1'b1) seen_rd = 1'b1;
      cyc++;
    end
    repeat (20) tick();
    checks++;
    if ({bus.busy, bus.eng_start, bus.rd_en, bus.eng_map_in} !== {3'b110, 16'd0}) begin
      errors++;
      $display("FAIL drain_state: got busy/start/rd=%b map_in=%0d want 110 0", {bus.busy, bus.eng_start, bus.rd_en}, bus.eng_map_in);
    end
    n_before = n_wr;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.err, bus.rd_en, bus.eng_rst, bus.eng_start, bus.wr_en} !== 7'b0000100) begin
      errors++;
      $display("FAIL async_reset_ctrl: got %b want 0000100", {bus.busy, bus.done, bus.err, bus.rd_en, bus.eng_rst, bus.eng_start, bus.wr_en});
    end
    checks++;
    if ({bus.rd_addr, bus.wr_addr, bus.wr_data, bus.eng_map_in} !== 59'd0) begin
      errors++;
      $display("FAIL async_reset_data: got rd_addr=%0d wr_addr=%0d wr_data=%0d want 0", bus.rd_addr, bus.wr_addr, bus.wr_data);
    end
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    checks++;
    if (n_wr !== n_before || n_done !== 0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got %0d writes %0d done busy=%b want %0d 0 0", n_wr, n_done, bus.busy, n_before);
    end
    $display("test_reset_mid_drain: writes before reset=%0d", n_before);
  endtask

  initial begin
    test_reset();
    test_full_map("first");
    test_timeout();
    test_abort();
    test_full_map("after_abort");
    test_reset_mid_drain();
    test_full_map("after_reset");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: got no finish by 1500000 ns want finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/conv_layer_seq.md
Name: conv_layer_seq

Overview:
Sequencer for one 9x9 convolution engine instance in the layer-1 path.
- On a command pulse it clears the engine and streams one input feature map from the frame buffer into the engine's pixel port.
- It opens the engine's start window, captures every saved output into the output map buffer, and reports done or error.
- Sits between the frame-buffer read port, the convolution engine and the output-map write port; one sequencer per engine.

Parameters:
IMG_PIX, 9216, input pixels per map (96x96)
START_OFFSET, 864, pixels presented before eng_start rises (9 rows x 96, shift-register prime)
OUT_NUM, 7744, engine outputs expected per map (88x88)
DRAIN_MAX, 1024, zero-pad cycles allowed after last pixel before timeout
IN_AW, 14, frame-buffer address width
OUT_AW, 13, output-buffer address width

Ports:
clk_in  in  1  single clock
rst_n  in  1  asynchronous active-low reset
cmd_start  in  1  one-cycle request to process a map
cmd_abort  in  1  cancel current map
busy  out  1  high from accepted cmd_start until return to IDLE
done  out  1  one-cycle pulse, map complete
err  out  1  sticky timeout flag, cleared by next accepted cmd_start
rd_en  out  1  frame-buffer read strobe
rd_addr  out  IN_AW  frame-buffer address
rd_data  in  16  signed pixel, valid 1 cycle after rd_en
eng_rst  out  1  active-high engine clear
eng_start  out  1  engine enable window
eng_map_in  out  16  signed pixel to engine, registered
eng_save  in  1  engine output-valid
eng_map_out  in  16  signed engine result
wr_en  out  1  output-buffer write strobe
wr_addr  out  OUT_AW  output-buffer address
wr_data  out  16  output-buffer data

Behaviour:
- Reset values: busy=0, done=0, err=0, rd_en=0, rd_addr=0, eng_rst=1, eng_start=0, eng_map_in=0, wr_en=0, wr_addr=0, wr_data=0; state=IDLE.
- eng_rst is held high in IDLE so the engine stays cleared.
- States are IDLE, CLEAR, FILL, RUN, DRAIN, DONE.
- IDLE: on cmd_start, go to CLEAR, set busy=1, clear err, zero all counters. cmd_start in any other state is ignored.
- CLEAR: one cycle with eng_rst=1; next state FILL with eng_rst=0.
- FILL/RUN (read side):
  - rd_en=1 and rd_addr increments 0..IMG_PIX-1, one pixel per cycle, no gaps.
  - rd_valid is rd_en delayed by one cycle.
  - eng_map_in <= rd_valid ? rd_data : 0, so pixel a reaches the engine 2 cycles after its read is issued.
  - pres_cnt counts valid pixels on eng_map_in.
- FILL -> RUN: in the cycle pres_cnt reaches START_OFFSET. eng_start rises that cycle and stays high until DONE or abort.
- RUN -> DRAIN: after the last pixel (IMG_PIX-1) is presented. rd_en is 0 after the last read issue.
- DRAIN: eng_map_in=0 and eng_start=1; drain_cnt counts cycles.
- Capture (in FILL/RUN/DRAIN):
  - Every cycle with eng_save=1, the next cycle has wr_en=1, wr_data=eng_map_out and wr_addr=out_cnt, then out_cnt increments.
  - eng_save while out_cnt==OUT_NUM is dropped (no write).
- Completion: when out_cnt reaches OUT_NUM in any of FILL/RUN/DRAIN, go to DONE. If reads remain, they are abandoned.
- DONE: one cycle with done=1, eng_start=0 and eng_rst=1; then IDLE with busy=0.
- Timeout: drain_cnt reaching DRAIN_MAX with out_cnt<OUT_NUM sets err=1, suppresses done and returns to IDLE (eng_rst=1).
- cmd_abort, any non-IDLE state:
  - Next cycle is IDLE: rd_en=0, wr_en=0, eng_start=0, eng_rst=1, busy=0, no done.
  - A write already pending from the preceding eng_save is discarded.
  - cmd_abort has priority over a simultaneous completion.
- rst_n low mid-operation forces reset values immediately (asynchronously). No partial write is issued after release.
- Counter widths: pres_cnt IN_AW+1, out_cnt OUT_AW+1, drain_cnt clog2(DRAIN_MAX)+1. No wrap inside a map.

Decomposition:
- Shared package: state enum, default geometry constants (96, 9, 88, IMG_PIX, START_OFFSET, OUT_NUM), pixel width 16.
- One natural sub-module, conv_out_capture: the eng_save-to-write register stage with out_cnt and the OUT_NUM saturation.
- FSM and read side stay in the top module.

Test Plan:
- Bench setup for all scenarios: behavioural engine model with saves in cycles 5..92 of each 96-cycle period after eng_start; ramp image, pixel = addr mod 2^16.
- Full map -> exactly 7744 writes at addresses 0..7743 matching the model, one done pulse, busy low the next cycle, err=0.
- Start alignment: eng_start rises exactly in the cycle the 864th pixel (value 863) is on eng_map_in; eng_rst high exactly one cycle before FILL.
- cmd_start pulses during RUN -> ignored, rd_addr sequence unbroken, single done.
- Engine model never asserts eng_save -> err=1 after 9216 pixels + 1024 drain cycles, no done, busy=0; next cmd_start clears err.
- cmd_abort at pixel 5000, same cycle as an eng_save -> no write, eng_rst=1 and busy=0 the next cycle; a following full run produces 7744 correct writes.
- rst_n asserted mid-DRAIN -> all outputs at reset values immediately, eng_rst=1; a rerun after release is correct.
